j_result_collector: RTL and testbench
=====================================

Name: j_result_collector

Overview:
- Receive end of the subarray result interface. Captures the per-row 16-bit results and result-enable pulses, which leave the rightmost column skewed in time by row.
- De-skews them through per-row FIFOs and emits one aligned H-row result vector on a valid/ready stream toward the output buffer.
- Raises an early stall request so the upstream mac_en feeder can pause, and flags any lost result.

Parameters:
- SUBARRAY_HEIGHT, 2: number of rows, i.e. result lanes.
- FIFO_DEPTH, 8: entries per row FIFO; must be a power of two and at least 4.
- AFULL_MARGIN, 2: stall_req asserts when any row count >= FIFO_DEPTH-AFULL_MARGIN.
- CNT_WIDTH, clog2(FIFO_DEPTH)+1: width of the per-row occupancy counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- result_in, input, 16*SUBARRAY_HEIGHT: row j result on bits [16*j +: 16], signed two's complement.
- result_en_in, input, SUBARRAY_HEIGHT: row j result valid for one cycle.
- out_data, output, 16*SUBARRAY_HEIGHT: aligned vector, row j on bits [16*j +: 16].
- out_valid, output, 1: out_data holds a complete vector.
- out_ready, input, 1: consumer accepts the vector.
- stall_req, output, 1: registered almost-full indication to the upstream feeder.
- overflow, output, 1: sticky flag; a result was dropped.
- clear_overflow, input, 1: clears overflow.
- vec_count, output, 16: number of vectors transferred, wraps modulo 2^16.

Behaviour:
- Reset values: all FIFO pointers and counts 0; out_valid=0; out_data=0; stall_req=0; overflow=0; vec_count=0. Reset wins over every other input. A reset during skewed arrival discards any partial vector.
- Row FIFO j push: result_en_in[j]=1 and (count_j<FIFO_DEPTH or pop this cycle). Data is written at wr_ptr_j and the pointer wraps modulo FIFO_DEPTH.
- Push while full with no pop: result is dropped, overflow<=1 on the next edge, and the FIFO is unchanged.
- Rows are independent. Any skew between rows is absorbed as long as no FIFO overflows.
- Output register stage:
  - out_valid/out_data form a one-entry register.
  - The register loads when every row FIFO is non-empty and (out_valid=0 or out_ready=1).
  - A load pops the head of all rows in the same cycle.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid drops after a transfer unless a reload happens in the same cycle.
  - Full throughput is 1 vector per cycle.
- Latency: the last-arriving row's result_en edge leads to out_valid high 2 cycles later (FIFO write, then register load).
- Simultaneous push and pop on the same row: both take effect; count is unchanged, including when the FIFO is full.
- stall_req is registered and equals (any count_j >= FIFO_DEPTH-AFULL_MARGIN) from the previous cycle. Upstream may still deliver up to AFULL_MARGIN in-flight results per row without loss.
- overflow:
  - Set by any drop.
  - clear_overflow=1 clears it.
  - Set and clear in the same cycle: set wins.
- vec_count increments on each transfer and wraps from 0xFFFF to 0x0000.
- The collector performs no arithmetic on data other than the optional clamp below.

Optional Feature:
- Macro: J_COLLECT_RELU_EN.
- Defined: each 16-bit lane is clamped at the output-register load. If bit 15 is 1, the stored value is 16'h0000; otherwise it passes unchanged. Zero added latency.
- Undefined: lanes pass unmodified.

Test Plan:
- H=2, row0 en at cycle 10 with 0x0005, row1 en at cycle 11 with 0xFFFE, out_ready=1 -> out_valid at cycle 13, out_data=0xFFFE_0005 (RELU_EN: 0x0000_0005), vec_count=1.
- Back-to-back: 8 skewed vectors, one per cycle, out_ready=1 -> 8 consecutive transfers in order, no overflow.
- out_ready=0, push 6 results per row (DEPTH 8, margin 2) -> stall_req=1 the cycle after count reaches 6. out_data holds the first vector stable.
- out_ready=0, push 10 per row -> 1 result per row stored in out_data, FIFOs full at 8, last result dropped, overflow=1. clear_overflow -> overflow=0. Then out_ready=1 drains 9 vectors in order.
- Full FIFO with a same-cycle push on one row and out_ready=1 -> count stays 8, no overflow, ordering preserved.
- Reset asserted mid-stream with rows partially filled -> next cycle out_valid=0, stall_req=0, vec_count=0. A fresh vector afterwards emerges correctly with no stale data.

Source files
------------

// File: rtl/j_result_collector.sv
// j_result_collector: receive end of the subarray result interface.
// Per-row FIFOs absorb the row-to-row skew of the result_en pulses; a
// one-entry output register presents one aligned vector per transfer on a
// valid/ready stream. stall_req is an early almost-full warning for the
// upstream feeder, and overflow is a sticky flag set when a result is lost.
// Optional build macro: J_COLLECT_RELU_EN clamps negative lanes to zero at
// the output-register load.
module j_result_collector #(
    parameter int SUBARRAY_HEIGHT = 2,
    parameter int FIFO_DEPTH      = 8,
    parameter int AFULL_MARGIN    = 2,
    parameter int CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [16*SUBARRAY_HEIGHT-1:0] result_in,
    input  logic [SUBARRAY_HEIGHT-1:0]    result_en_in,
    output logic [16*SUBARRAY_HEIGHT-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          stall_req,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [15:0]                   vec_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AFULL_CNT = CNT_WIDTH'(FIFO_DEPTH - AFULL_MARGIN);

    logic [SUBARRAY_HEIGHT-1:0]    row_nonempty;
    logic [SUBARRAY_HEIGHT-1:0]    row_afull;
    logic [SUBARRAY_HEIGHT-1:0]    row_drop;
    logic [16*SUBARRAY_HEIGHT-1:0] load_data;

    logic [16*SUBARRAY_HEIGHT-1:0] out_data_reg;
    logic                          out_valid_reg;
    logic                          stall_req_reg;
    logic                          overflow_reg;
    logic [15:0]                   vec_count_reg;

    logic load;
    logic transfer;

    // A new vector can be formed only when every row has its head result
    // ready, and only into an empty register or one being drained this cycle.
    assign load     = (&row_nonempty) && (!out_valid_reg || out_ready);
    assign transfer = out_valid_reg && out_ready;

    generate
        for (genvar gi = 0; gi < SUBARRAY_HEIGHT; gi++) begin : row_g
            logic [15:0]          mem [FIFO_DEPTH];
            logic [PTR_W-1:0]     wr_ptr_reg;
            logic [PTR_W-1:0]     rd_ptr_reg;
            logic [CNT_WIDTH-1:0] count_reg;
            logic                 push;
            logic [15:0]          head;

            // A full row still accepts a result when the same cycle pops it.
            assign push = result_en_in[gi] && ((count_reg < FULL_CNT) || load);
            assign head = mem[rd_ptr_reg];

            assign row_nonempty[gi] = (count_reg != '0);
            assign row_afull[gi]    = (count_reg >= AFULL_CNT);
            assign row_drop[gi]     = result_en_in[gi] && !push;

`ifdef J_COLLECT_RELU_EN
            assign load_data[16*gi +: 16] = head[15] ? 16'h0000 : head;
`else
            assign load_data[16*gi +: 16] = head;
`endif

            // Storage array: written on accepted pushes, no reset needed.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= result_in[16*gi +: 16];
                end
            end

            // Pointer and occupancy bookkeeping; pointers wrap naturally.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (load) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    if (push && !load) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (!push && load) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // One-entry output register: load has priority over emptying on transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= load_data;
        end else if (transfer) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Almost-full warning, registered so the feeder sees a clean signal.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_req_reg <= 1'b0;
        end else begin
            stall_req_reg <= |row_afull;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (|row_drop) begin
            overflow_reg <= 1'b1;
        end else if (clear_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

    // Transfer counter, wraps modulo 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_count_reg <= '0;
        end else if (transfer) begin
            vec_count_reg <= vec_count_reg + 16'd1;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign stall_req = stall_req_reg;
    assign overflow  = overflow_reg;
    assign vec_count = vec_count_reg;

endmodule

// File: tb/tb_j_result_collector.sv
// Scoreboard bench for j_result_collector (H=2, depth 8, margin 2).
// Stimulus pushes expected vectors into a queue; a negedge monitor pops
// and compares on every transfer and checks stability while stalled.
module tb_j_result_collector;

    localparam int H = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [16*H-1:0] result_in;
    logic [H-1:0]  result_en_in;
    logic [16*H-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          stall_req;
    logic          overflow;
    logic          clear_overflow;
    logic [15:0]   vec_count;

    logic [31:0]   exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            exp_cnt = 0;

    always #5 clk = ~clk;

    j_result_collector #(
        .SUBARRAY_HEIGHT(2),
        .FIFO_DEPTH(8),
        .AFULL_MARGIN(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .result_in(result_in),
        .result_en_in(result_en_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .stall_req(stall_req),
        .overflow(overflow),
        .clear_overflow(clear_overflow),
        .vec_count(vec_count)
    );

    function automatic logic [15:0] clamp(input logic [15:0] v);
`ifdef J_COLLECT_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] vec(input logic [15:0] r0, input logic [15:0] r1);
        return {clamp(r1), clamp(r0)};
    endfunction

    function automatic logic [15:0] r0v(input int i);
        return 16'(16'h0100 + i);
    endfunction

    function automatic logic [15:0] r1v(input int i);
        return (i % 2 == 1) ? 16'(16'hF000 + i) : 16'(16'h0200 + i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of results, then return the enables to idle.
    task automatic drive(input logic [1:0] en, input logic [15:0] d0, input logic [15:0] d1);
        result_en_in = en;
        result_in    = {d1, d0};
        tick();
        result_en_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    // Wait (bounded) until every expected vector has been transferred.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        tick();
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_vec_count"}, 32'(vec_count), 32'(exp_cnt));
    endtask

    // Monitor: compare each transfer to the scoreboard, and check that a
    // stalled vector does not change or vanish.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_vec: got 0x%08h, required no vector", out_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("vec", out_data, e);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        result_in      = '0;
        result_en_in   = '0;
        out_ready      = 1'b1;
        clear_overflow = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_stall_req", 32'(stall_req), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_vec_count", 32'(vec_count), 32'd0);

        // Skewed single vector: row1 arrives one cycle after row0.
        drive(2'b01, 16'h0005, 16'h0000);
        exp_q.push_back(vec(16'h0005, 16'hFFFE));
        exp_cnt++;
        drive(2'b10, 16'h0000, 16'hFFFE);
        check("lat_plus1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_plus2_valid", 32'(out_valid), 32'd1);
        tick();
        check("single_vec_count", 32'(vec_count), 32'(exp_cnt));
        check("single_valid_drop", 32'(out_valid), 32'd0);

        // Back-to-back skewed stream, one vector per cycle.
        for (int i = 0; i < 9; i++) begin
            logic [1:0] en;
            en = {(i >= 1) ? 1'b1 : 1'b0, (i < 8) ? 1'b1 : 1'b0};
            if (i >= 1) begin
                exp_q.push_back(vec(r0v(i - 1), r1v(i - 1)));
                exp_cnt++;
            end
            drive(en, r0v(i), r1v(i - 1));
        end
        drain("b2b");
        check("b2b_overflow", 32'(overflow), 32'd0);

        // Stall: 7 aligned pushes with out_ready low -> FIFO count 6.
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back(vec(16'(16'h0300 + k), 16'(16'h8300 + k)));
            exp_cnt++;
            drive(2'b11, 16'(16'h0300 + k), 16'(16'h8300 + k));
        end
        check("stall_not_yet", 32'(stall_req), 32'd0);
        tick();
        check("stall_asserted", 32'(stall_req), 32'd1);
        check("stall_head_data", out_data, vec(16'h0301, 16'h8301));
        out_ready = 1'b1;
        drain("stall");
        check("stall_released", 32'(stall_req), 32'd0);

        // Overflow: 10 pushes per row with out_ready low; 10th is dropped.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(vec(16'(16'h0400 + k), 16'(16'h0500 + k)));
            exp_cnt++;
            drive(2'b11, 16'(16'h0400 + k), 16'(16'h0500 + k));
        end
        check("ovf_before_drop", 32'(overflow), 32'd0);
        drive(2'b11, 16'h0EEE, 16'h0FFF);
        check("ovf_after_drop", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        drain("ovf");

        // Full FIFO with push on one row during a pop.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(vec(16'(16'h0600 + k), 16'(16'h0700 + k)));
            exp_cnt++;
            drive(2'b11, 16'(16'h0600 + k), 16'(16'h0700 + k));
        end
        out_ready = 1'b1;
        drive(2'b01, 16'h06AA, 16'h0000);
        out_ready = 1'b0;
        exp_q.push_back(vec(16'h06AA, 16'h07BB));
        exp_cnt++;
        drive(2'b10, 16'h0000, 16'h07BB);
        check("full_pushpop_no_ovf", 32'(overflow), 32'd0);
        // Drop coinciding with clear: the set must win.
        clear_overflow = 1'b1;
        drive(2'b01, 16'h0DDD, 16'h0000);
        clear_overflow = 1'b0;
        check("ovf_set_beats_clear", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        drain("full");

        // Reset mid-stream with partial rows; reset wins over enables.
        out_ready = 1'b0;
        drive(2'b11, 16'h0111, 16'h0222);
        drive(2'b01, 16'h0333, 16'h0000);
        drive(2'b01, 16'h0444, 16'h0000);
        reset        = 1'b1;
        result_en_in = 2'b11;
        result_in    = {16'h0999, 16'h0888};
        tick();
        reset        = 1'b0;
        result_en_in = '0;
        exp_q.delete();
        exp_cnt = 0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_stall_req", 32'(stall_req), 32'd0);
        check("midrst_vec_count", 32'(vec_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        exp_q.push_back(vec(16'h7FFF, 16'h8001));
        exp_cnt++;
        drive(2'b11, 16'h7FFF, 16'h8001);
        drain("fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
